// File: rtl/instruction_decode.sv
// ID stage of the TP4 MIPS core: decode, register file, branch/jump resolution and hazard stalls.
// Define ID_BRANCH_FWD_EN to forward the EX/MEM ALU result to branch/jr sources without a stall.
module instruction_decode #(
  parameter int unsigned len     = 32,
  parameter int unsigned NB_ADDR = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        in_instruction,
  input  logic [len-1:0]     in_pc_branch,
  input  logic               in_wb_reg_write,
  input  logic [NB_ADDR-1:0] in_wb_addr,
  input  logic [len-1:0]     in_wb_data,
  input  logic               in_mem_reg_write,
  input  logic               in_mem_mem_to_reg,
  input  logic [NB_ADDR-1:0] in_mem_addr,
  input  logic [len-1:0]     in_mem_alu_result,
  output logic [2:0]         out_pc_src,
  output logic [len-1:0]     out_pc_branch,
  output logic [len-1:0]     out_pc_jump,
  output logic [len-1:0]     out_pc_register,
  output logic               out_pc_enable,
  output logic [len-1:0]     out_rs_data,
  output logic [len-1:0]     out_rt_data,
  output logic [len-1:0]     out_imm,
  output logic [4:0]         out_shamt,
  output logic [NB_ADDR-1:0] out_rs,
  output logic [NB_ADDR-1:0] out_rt,
  output logic [NB_ADDR-1:0] out_dest,
  output logic [3:0]         out_alu_op,
  output logic               out_alu_src,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic               out_mem_to_reg,
  output logic               out_reg_write,
  output logic               out_link,
  output logic [len-1:0]     out_pc_link
);

  localparam int unsigned NumRegs = 2 ** NB_ADDR;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpXori  = 6'h0e;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor, AluSlt, AluSltu,
    AluSll, AluSrl, AluSra, AluSllv, AluSrlv, AluSrav, AluLui
  } alu_op_e;

  typedef struct packed {
    logic [len-1:0]     rs_data;
    logic [len-1:0]     rt_data;
    logic [len-1:0]     imm;
    logic [4:0]         shamt;
    logic [NB_ADDR-1:0] rs;
    logic [NB_ADDR-1:0] rt;
    logic [NB_ADDR-1:0] dest;
    alu_op_e            alu_op;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic               link;
    logic [len-1:0]     pc_link;
  } idex_t;

  idex_t idex_d, idex_q;
  logic [NumRegs-1:0][len-1:0] rf_d, rf_q;

  logic [5:0]         opcode, funct;
  logic [NB_ADDR-1:0] rs, rt, rd, dest;
  logic [15:0]        imm16;
  logic [len-1:0]     imm_sext, imm_ext;
  logic [len-1:0]     rs_val, rt_val, br_rs_val, br_rt_val;
  alu_op_e            alu_op;
  logic ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_alu_src, ctl_link;
  logic use_rs, use_rt, is_beq, is_bne, is_jump, is_jreg;
  logic mem_hazard, mem_fwd, rs_br_hit, rt_br_hit, ld_use, br_stall, stall, taken;

  assign opcode   = in_instruction[31:26];
  assign rs       = in_instruction[21 +: NB_ADDR];
  assign rt       = in_instruction[16 +: NB_ADDR];
  assign rd       = in_instruction[11 +: NB_ADDR];
  assign funct    = in_instruction[5:0];
  assign imm16    = in_instruction[15:0];
  assign imm_sext = {{(len-16){imm16[15]}}, imm16};

  // EX/MEM results that can't reach a branch source this cycle force a stall.
`ifdef ID_BRANCH_FWD_EN
  assign mem_hazard = in_mem_mem_to_reg;
  assign mem_fwd    = in_mem_reg_write & ~in_mem_mem_to_reg;
`else
  assign mem_hazard = in_mem_reg_write | in_mem_mem_to_reg;
  assign mem_fwd    = 1'b0;
`endif

  always_comb begin
    rf_d = rf_q;
    if (in_wb_reg_write && in_wb_addr != '0) rf_d[in_wb_addr] = in_wb_data;
  end

  // Register reads with write-through from the WB port.
  always_comb begin
    rs_val = rf_q[rs];
    rt_val = rf_q[rt];
    if (rs == '0) rs_val = '0;
    else if (in_wb_reg_write && in_wb_addr == rs) rs_val = in_wb_data;
    if (rt == '0) rt_val = '0;
    else if (in_wb_reg_write && in_wb_addr == rt) rt_val = in_wb_data;
    br_rs_val = (mem_fwd && rs != '0 && rs == in_mem_addr) ? in_mem_alu_result : rs_val;
    br_rt_val = (mem_fwd && rt != '0 && rt == in_mem_addr) ? in_mem_alu_result : rt_val;
  end

  always_comb begin
    ctl_reg_write = 1'b0;
    ctl_mem_read  = 1'b0;
    ctl_mem_write = 1'b0;
    ctl_alu_src   = 1'b0;
    ctl_link      = 1'b0;
    alu_op        = AluAdd;
    use_rs        = 1'b0;
    use_rt        = 1'b0;
    is_beq        = 1'b0;
    is_bne        = 1'b0;
    is_jump       = 1'b0;
    is_jreg       = 1'b0;
    dest          = rt;
    imm_ext       = imm_sext;
    case (opcode)
      OpRtype: begin
        dest          = rd;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
        ctl_reg_write = 1'b1;
        case (funct)
          FnSll:         begin alu_op = AluSll; use_rs = 1'b0; end
          FnSrl:         begin alu_op = AluSrl; use_rs = 1'b0; end
          FnSra:         begin alu_op = AluSra; use_rs = 1'b0; end
          FnSllv:        alu_op = AluSllv;
          FnSrlv:        alu_op = AluSrlv;
          FnSrav:        alu_op = AluSrav;
          FnJr:          begin is_jreg = 1'b1; use_rt = 1'b0; ctl_reg_write = 1'b0; end
          FnJalr:        begin is_jreg = 1'b1; use_rt = 1'b0; ctl_link = 1'b1; end
          FnAdd, FnAddu: alu_op = AluAdd;
          FnSub, FnSubu: alu_op = AluSub;
          FnAnd:         alu_op = AluAnd;
          FnOr:          alu_op = AluOr;
          FnXor:         alu_op = AluXor;
          FnNor:         alu_op = AluNor;
          FnSlt:         alu_op = AluSlt;
          FnSltu:        alu_op = AluSltu;
          default:       begin ctl_reg_write = 1'b0; use_rs = 1'b0; use_rt = 1'b0; end
        endcase
      end
      OpJ:     is_jump = 1'b1;
      OpJal:   begin is_jump = 1'b1; ctl_link = 1'b1; ctl_reg_write = 1'b1; dest = '1; end
      OpBeq:   begin is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; alu_op = AluSub; end
      OpBne:   begin is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; alu_op = AluSub; end
      OpAddi, OpAddiu: begin
        use_rs = 1'b1; ctl_alu_src = 1'b1; ctl_reg_write = 1'b1;
      end
      OpSlti:  begin use_rs = 1'b1; ctl_alu_src = 1'b1; ctl_reg_write = 1'b1; alu_op = AluSlt; end
      OpSltiu: begin use_rs = 1'b1; ctl_alu_src = 1'b1; ctl_reg_write = 1'b1; alu_op = AluSltu; end
      OpAndi, OpOri, OpXori: begin
        use_rs        = 1'b1;
        ctl_alu_src   = 1'b1;
        ctl_reg_write = 1'b1;
        imm_ext       = {{(len-16){1'b0}}, imm16};
        alu_op        = (opcode == OpAndi) ? AluAnd : (opcode == OpOri) ? AluOr : AluXor;
      end
      OpLui: begin
        ctl_alu_src = 1'b1; ctl_reg_write = 1'b1; alu_op = AluLui;
        imm_ext     = {imm16, {(len-16){1'b0}}};
      end
      OpLw:    begin use_rs = 1'b1; ctl_alu_src = 1'b1; ctl_reg_write = 1'b1; ctl_mem_read = 1'b1; end
      OpSw:    begin use_rs = 1'b1; use_rt = 1'b1; ctl_alu_src = 1'b1; ctl_mem_write = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    ld_use = idex_q.mem_read && idex_q.dest != '0 &&
             ((use_rs && rs == idex_q.dest) || (use_rt && rt == idex_q.dest));
    rs_br_hit = (rs != '0) && ((idex_q.reg_write && rs == idex_q.dest) ||
                               (mem_hazard && rs == in_mem_addr));
    rt_br_hit = (rt != '0) && ((idex_q.reg_write && rt == idex_q.dest) ||
                               (mem_hazard && rt == in_mem_addr));
    br_stall = ((is_beq || is_bne || is_jreg) && rs_br_hit) || ((is_beq || is_bne) && rt_br_hit);
    stall    = ld_use || br_stall;
    taken    = (is_beq && br_rs_val == br_rt_val) || (is_bne && br_rs_val != br_rt_val);
  end

  // Redirect outputs are forced idle while reset is held.
  always_comb begin
    out_pc_enable   = 1'b1;
    out_pc_src      = 3'b000;
    out_pc_branch   = '0;
    out_pc_jump     = '0;
    out_pc_register = '0;
    if (reset) begin
      out_pc_branch   = in_pc_branch + imm_sext;
      out_pc_jump     = {in_pc_branch[len-1:26], in_instruction[25:0]};
      out_pc_register = br_rs_val;
      if (stall)        out_pc_enable = 1'b0;
      else if (taken)   out_pc_src    = 3'b001;
      else if (is_jump) out_pc_src    = 3'b011;
      else if (is_jreg) out_pc_src    = 3'b101;
    end
  end

  always_comb begin
    idex_d = '0;
    if (!stall) begin
      idex_d.rs_data    = rs_val;
      idex_d.rt_data    = rt_val;
      idex_d.imm        = imm_ext;
      idex_d.shamt      = in_instruction[10:6];
      idex_d.rs         = rs;
      idex_d.rt         = rt;
      idex_d.dest       = dest;
      idex_d.alu_op     = alu_op;
      idex_d.alu_src    = ctl_alu_src;
      idex_d.mem_read   = ctl_mem_read;
      idex_d.mem_write  = ctl_mem_write;
      idex_d.mem_to_reg = ctl_mem_read;
      idex_d.reg_write  = ctl_reg_write && dest != '0;
      idex_d.link       = ctl_link;
      idex_d.pc_link    = ctl_link ? in_pc_branch : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q <= '0;
      rf_q   <= '0;
    end else begin
      idex_q <= idex_d;
      rf_q   <= rf_d;
    end
  end

  assign out_rs_data    = idex_q.rs_data;
  assign out_rt_data    = idex_q.rt_data;
  assign out_imm        = idex_q.imm;
  assign out_shamt      = idex_q.shamt;
  assign out_rs         = idex_q.rs;
  assign out_rt         = idex_q.rt;
  assign out_dest       = idex_q.dest;
  assign out_alu_op     = idex_q.alu_op;
  assign out_alu_src    = idex_q.alu_src;
  assign out_mem_read   = idex_q.mem_read;
  assign out_mem_write  = idex_q.mem_write;
  assign out_mem_to_reg = idex_q.mem_to_reg;
  assign out_reg_write  = idex_q.reg_write;
  assign out_link       = idex_q.link;
  assign out_pc_link    = idex_q.pc_link;

endmodule
